// File: rtl/pixel_pkg.sv
// Shared constants and state encoding for the pixel readout capture path.
package pixel_pkg;
  localparam int unsigned ROWS          = 2;
  localparam int unsigned ADC_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPOSE,
    ST_READ,
    ST_DRAIN
  } state_t;
endpackage

// File: rtl/sig_edge_detect.sv
// Registers a synchronous input once and flags its rising and falling edges.
module sig_edge_detect (
  input  logic Clk,
  input  logic Reset,
  input  logic sig,
  output logic rise,
  output logic fall
);
  logic sig_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) sig_q <= 1'b0;
    else       sig_q <= sig;
  end

  assign rise = sig & ~sig_q;
  assign fall = ~sig & sig_q;
endmodule

// File: rtl/pixel_readout_capture.sv
// Captures two ADC rows per frame from the readout sequence and streams the
// frame pixel-serially over a valid/ready port.
module pixel_readout_capture
  import pixel_pkg::*;
#(
  parameter int unsigned COLS   = 2,
  parameter int unsigned ADC_W  = ADC_W_DEFAULT,
  parameter int unsigned FCNT_W = 8
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Expose,
  input  logic                  Erase,
  input  logic                  NRE_1,
  input  logic                  NRE_2,
  input  logic                  ADC,
  input  logic [COLS*ADC_W-1:0] AdcData,
  output logic [ADC_W-1:0]      OutData,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic                  OutFirst,
  output logic                  OutLast,
  output logic                  Busy,
  output logic [FCNT_W-1:0]     FrameCnt,
  output logic                  ProtoErr,
  output logic                  OverrunErr,
  output logic                  AbortErr
);
  localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  state_t            state_q, state_d;
  logic [ROWS-1:0]   mask_q;
  logic [ADC_W-1:0]  pix [ROWS][COLS];
  logic              row_idx;
  logic [COL_W-1:0]  col_idx;
  logic [FCNT_W-1:0] frame_cnt_q;
  logic              proto_q, overrun_q, abort_q;

  logic expose_rise, expose_fall;
  logic erase_rise, erase_fall_unused;
  logic adc_rise_unused, adc_fall;

  sig_edge_detect u_expose_edge (
    .Clk (Clk), .Reset (Reset), .sig (Expose), .rise (expose_rise), .fall (expose_fall)
  );
  sig_edge_detect u_erase_edge (
    .Clk (Clk), .Reset (Reset), .sig (Erase), .rise (erase_rise), .fall (erase_fall_unused)
  );
  sig_edge_detect u_adc_edge (
    .Clk (Clk), .Reset (Reset), .sig (ADC), .rise (adc_rise_unused), .fall (adc_fall)
  );

  logic row_ok, cap_row, abort, cap_ok, proto_d, last_pix, accept;

  assign row_ok   = NRE_1 ^ NRE_2;
  assign cap_row  = NRE_2;
  // Abort takes priority over a capture or an exposure end on the same edge.
  assign abort    = erase_rise && (state_q == ST_EXPOSE || state_q == ST_READ);
  assign cap_ok   = adc_fall && row_ok && (state_q == ST_READ) && !abort;
  assign proto_d  = adc_fall && !abort &&
                    ((state_q == ST_EXPOSE) || (state_q == ST_READ && !row_ok));
  assign last_pix = row_idx && (col_idx == COL_LAST);
  assign accept   = OutValid && OutReady;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (expose_rise) state_d = ST_EXPOSE;
      ST_EXPOSE: if (abort) state_d = ST_IDLE;
                 else if (expose_fall) state_d = ST_READ;
      ST_READ:   if (abort) state_d = ST_IDLE;
                 else if (&mask_q) state_d = ST_DRAIN;
      ST_DRAIN:  if (accept && last_pix) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mask_q      <= '0;
      row_idx     <= 1'b0;
      col_idx     <= '0;
      frame_cnt_q <= '0;
      proto_q     <= 1'b0;
      overrun_q   <= 1'b0;
      abort_q     <= 1'b0;
      for (int unsigned r = 0; r < ROWS; r++)
        for (int unsigned c = 0; c < COLS; c++)
          pix[r][c] <= '0;
    end else begin
      proto_q   <= proto_d;
      overrun_q <= expose_rise && (state_q == ST_DRAIN);
      abort_q   <= abort;

      if (abort || (state_q == ST_IDLE && expose_rise)) mask_q <= '0;
      else if (cap_ok) mask_q[cap_row] <= 1'b1;

      if (cap_ok)
        for (int unsigned c = 0; c < COLS; c++)
          pix[cap_row][c] <= AdcData[c*ADC_W +: ADC_W];

      if (accept) begin
        if (last_pix) begin
          row_idx     <= 1'b0;
          col_idx     <= '0;
          frame_cnt_q <= frame_cnt_q + 1'b1;
        end else if (col_idx == COL_LAST) begin
          row_idx <= 1'b1;
          col_idx <= '0;
        end else begin
          col_idx <= col_idx + 1'b1;
        end
      end
    end
  end

  assign OutValid   = (state_q == ST_DRAIN);
  assign OutData    = OutValid ? pix[row_idx][col_idx] : '0;
  assign OutFirst   = OutValid && !row_idx && (col_idx == '0);
  assign OutLast    = OutValid && last_pix;
  assign Busy       = (state_q != ST_IDLE);
  assign FrameCnt   = frame_cnt_q;
  assign ProtoErr   = proto_q;
  assign OverrunErr = overrun_q;
  assign AbortErr   = abort_q;
endmodule

// File: tb/tb_pixel_readout_capture.sv
// Scoreboard bench for pixel_readout_capture with COLS=2, ADC_W=8.
module tb_pixel_readout_capture;
  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Expose = 1'b0, Erase = 1'b0, NRE_1 = 1'b0, NRE_2 = 1'b0, ADC = 1'b0;
  logic [15:0] AdcData = '0;
  logic [7:0]  OutData;
  logic        OutValid, OutReady, OutFirst, OutLast, Busy;
  logic [7:0]  FrameCnt;
  logic        ProtoErr, OverrunErr, AbortErr;

  pixel_readout_capture #(.COLS(2), .ADC_W(8), .FCNT_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .Expose(Expose), .Erase(Erase), .NRE_1(NRE_1),
    .NRE_2(NRE_2), .ADC(ADC), .AdcData(AdcData), .OutData(OutData),
    .OutValid(OutValid), .OutReady(OutReady), .OutFirst(OutFirst), .OutLast(OutLast),
    .Busy(Busy), .FrameCnt(FrameCnt), .ProtoErr(ProtoErr), .OverrunErr(OverrunErr),
    .AbortErr(AbortErr)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       first;
    logic       last;
    logic [7:0] data;
  } pix_t;

  pix_t sb[$];
  int   n_compared = 0;
  int   n_mismatched = 0;
  logic [7:0] exp_fc = '0;
  logic ready_level = 1'b1;
  logic bp_mode = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    OutReady = 1'b1;
    forever begin
      @(posedge Clk);
      #1;
      if (bp_mode) OutReady = ~OutReady;
      else         OutReady = ready_level;
    end
  end

  // Output monitor: pops one expected word per handshake, checks holding while stalled.
  logic prev_stall = 1'b0;
  pix_t held;
  always @(negedge Clk) begin
    pix_t e;
    if (Reset) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        check("hold_data", OutData, held.data);
        check("hold_first", OutFirst, held.first);
        check("hold_last", OutLast, held.last);
        check("hold_valid", OutValid, 1'b1);
      end
      if (OutValid && OutReady) begin
        if (sb.size() == 0) check("spurious_valid", OutValid, 1'b0);
        else begin
          e = sb.pop_front();
          check("out_data", OutData, e.data);
          check("out_first", OutFirst, e.first);
          check("out_last", OutLast, e.last);
        end
      end
      prev_stall = OutValid && !OutReady;
      held = '{first: OutFirst, last: OutLast, data: OutData};
    end
  end

  task automatic push_frame(input logic [15:0] d0, input logic [15:0] d1);
    sb.push_back('{first: 1'b1, last: 1'b0, data: d0[7:0]});
    sb.push_back('{first: 1'b0, last: 1'b0, data: d0[15:8]});
    sb.push_back('{first: 1'b0, last: 1'b0, data: d1[7:0]});
    sb.push_back('{first: 1'b0, last: 1'b1, data: d1[15:8]});
    exp_fc = exp_fc + 8'd1;
  endtask

  task automatic strobe(input logic n1, input logic n2, input logic [15:0] d);
    NRE_1 = n1; NRE_2 = n2; AdcData = d; ADC = 1'b1;
    tick();
    ADC = 1'b0;
    tick();
    NRE_1 = 1'b0; NRE_2 = 1'b0;
  endtask

  task automatic run_frame(input logic [15:0] d0, input logic [15:0] d1, input logic expect_out);
    if (expect_out) push_frame(d0, d1);
    Expose = 1'b1; tick();
    Expose = 1'b0; tick();
    strobe(1'b1, 1'b0, d0);
    strobe(1'b0, 1'b1, d1);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 50 && !OutValid; i++) tick();
    check("valid_timeout", OutValid, 1'b1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) tick();
    check("drain_timeout", sb.size(), 0);
    tick(); tick();
    check("busy_idle", Busy, 1'b0);
    check("frame_cnt", FrameCnt, exp_fc);
  endtask

  initial begin
    #12;
    check("rst_valid", OutValid, 1'b0);
    check("rst_data", OutData, 8'h00);
    check("rst_busy", Busy, 1'b0);
    check("rst_fcnt", FrameCnt, 8'h00);
    check("rst_errs", {ProtoErr, OverrunErr, AbortErr, OutFirst, OutLast}, 5'b0);
    tick();
    Reset = 1'b0;
    tick();

    // Nominal frame, no bubbles, valid one cycle after completing capture.
    run_frame(16'h2211, 16'h4433, 1'b1);
    @(negedge Clk);
    check("valid_lat0", OutValid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      check("valid_burst", OutValid, 1'b1);
    end
    @(negedge Clk);
    check("valid_after_last", OutValid, 1'b0);
    #1;
    wait_drain();

    // Backpressure.
    bp_mode = 1'b1;
    run_frame(16'hA5B6, 16'hC7D8, 1'b1);
    wait_drain();
    bp_mode = 1'b0;
    tick();

    // Abort after row0, then a clean frame.
    Expose = 1'b1; tick();
    Expose = 1'b0; tick();
    strobe(1'b1, 1'b0, 16'hDEAD);
    Erase = 1'b1; tick();
    check("abort_pulse", AbortErr, 1'b1);
    check("abort_busy", Busy, 1'b0);
    Erase = 1'b0; tick();
    check("abort_clear", AbortErr, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    check("abort_no_valid", OutValid, 1'b0);
    run_frame(16'h0201, 16'h0403, 1'b1);
    wait_drain();

    // Protocol errors: strobe during exposure and with both row enables.
    push_frame(16'h1357, 16'h2468);
    Expose = 1'b1; tick();
    strobe(1'b0, 1'b1, 16'hEEEE);
    check("proto_expose", ProtoErr, 1'b1);
    Expose = 1'b0; tick();
    check("proto_clear", ProtoErr, 1'b0);
    strobe(1'b1, 1'b0, 16'h1357);
    check("proto_none", ProtoErr, 1'b0);
    strobe(1'b1, 1'b1, 16'hFFFF);
    check("proto_both", ProtoErr, 1'b1);
    strobe(1'b0, 1'b1, 16'h2468);
    wait_drain();

    // Overrun: exposure starts while the previous frame is stalled.
    ready_level = 1'b0;
    run_frame(16'h6655, 16'h8877, 1'b1);
    wait_valid();
    Expose = 1'b1; tick();
    check("overrun_pulse", OverrunErr, 1'b1);
    check("overrun_busy", Busy, 1'b1);
    Expose = 1'b0; tick();
    strobe(1'b1, 1'b0, 16'hBBBB);
    strobe(1'b0, 1'b1, 16'hCCCC);
    ready_level = 1'b1;
    wait_drain();
    for (int i = 0; i < 6; i++) tick();
    check("overrun_no_rearm", Busy, 1'b0);

    // Asynchronous reset mid-drain.
    ready_level = 1'b0;
    run_frame(16'h3030, 16'h4040, 1'b0);
    wait_valid();
    #2 Reset = 1'b1;
    #1;
    check("areset_valid", OutValid, 1'b0);
    check("areset_data", OutData, 8'h00);
    check("areset_busy", Busy, 1'b0);
    check("areset_fcnt", FrameCnt, 8'h00);
    exp_fc = '0;
    tick();
    #2 Reset = 1'b0;
    ready_level = 1'b1;
    tick();

    // Frame counter wraps after 256 frames.
    for (int f = 0; f < 256; f++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      b = 16'($urandom);
      run_frame(a, b, 1'b1);
      wait_drain();
      if (f == 254) check("fcnt_255", FrameCnt, 8'd255);
    end
    check("fcnt_wrap", FrameCnt, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #2000000;
    n_mismatched++;
    $display("FAIL global_timeout: got running expected finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $fatal(1, "timeout");
  end
endmodule
